// File: rtl/pio_hex_display_ctrl_if.sv
// Avalon-MM slave bus bundle for pio_hex_display_ctrl.
// Signals:
//   address    - register select (3 bits)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data (32 bits)
//   readdata   - combinational read data (32 bits)
// Modports: master (bus driver), slave (the display controller).
interface pio_hex_display_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_hex_display_ctrl.sv
// Seven-segment display PIO: raw segment register with atomic set/clear,
// per-digit blinking from a programmable half-period, registered output.
// Optional macro PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN adds a nibble-to-segment
// decode write port at address 6.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   bus      - Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port - segment drive, digit i at [7i+6:7i], bit0 = segment a
// Register map: 0 DATA, 1 BLINK_MASK, 2 BLINK_HALF, 3 STATUS (RO),
//               4 OUTSET (WO), 5 OUTCLEAR (WO), 6 HEX (WO, optional), 7 reserved.
module pio_hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned BLINK_CNT_W    = 26,
    parameter int unsigned BLINK_HALF_RST = 25000000,
    parameter logic [7*NUM_DIGITS-1:0] RESET_DATA = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    pio_hex_display_ctrl_if.slave     bus,
    output logic [7*NUM_DIGITS-1:0]   out_port
);

    localparam int unsigned W = 7 * NUM_DIGITS;
    localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_HALF     = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_HEX      = 3'd6;

`ifdef PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN
    localparam logic DECODE_PRESENT = 1'b1;
`else
    localparam logic DECODE_PRESENT = 1'b0;
`endif

    logic [W-1:0]           data_q, data_d;
    logic [NUM_DIGITS-1:0]  mask_q;
    logic [BLINK_CNT_W-1:0] half_q;
    logic [BLINK_CNT_W-1:0] cnt_q;
    logic                   phase_q;
    logic [W-1:0]           out_d;
    logic                   wr;
    logic                   wr_half;
    logic                   unused_wdata;

    assign wr      = bus.chipselect && !bus.write_n;
    assign wr_half = wr && (bus.address == ADDR_HALF);

    // Bits of writedata above the register widths are intentionally dropped.
    assign unused_wdata = ^bus.writedata;

`ifdef PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN
    // Standard 0-F font, active-high (bit0 = segment a).
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [W-1:0] hex_data;

    // One nibble per digit, polarity matched to the board.
    always_comb begin
        hex_data = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            hex_data[7*i +: 7] = ACTIVE_LOW ? ~hex_font(bus.writedata[4*i +: 4])
                                            :  hex_font(bus.writedata[4*i +: 4]);
        end
    end
`endif

    // Next DATA value: plain write, atomic set/clear, optional decode.
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:     data_d = bus.writedata[W-1:0];
                ADDR_OUTSET:   data_d = data_q | bus.writedata[W-1:0];
                ADDR_OUTCLEAR: data_d = data_q & ~bus.writedata[W-1:0];
`ifdef PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN
                ADDR_HEX:      data_d = hex_data;
`endif
                default:       data_d = data_q;
            endcase
        end
    end

    // Register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_DATA;
            mask_q <= '0;
            half_q <= BLINK_CNT_W'(BLINK_HALF_RST);
        end else begin
            data_q <= data_d;
            if (wr && (bus.address == ADDR_MASK)) begin
                mask_q <= bus.writedata[NUM_DIGITS-1:0];
            end
            if (wr_half) begin
                half_q <= bus.writedata[BLINK_CNT_W-1:0];
            end
        end
    end

    // Blink timebase; a BLINK_HALF write restarts the period lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (wr_half || (half_q == '0)) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (cnt_q == (half_q - BLINK_CNT_W'(1))) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + BLINK_CNT_W'(1);
        end
    end

    // Blanked digits show OFF during the dark half of the blink period.
    always_comb begin
        out_d = data_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (mask_q[i] && !phase_q) begin
                out_d[7*i +: 7] = SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port <= RESET_DATA;
        end else begin
            out_port <= out_d;
        end
    end

    // Combinational read mux, independent of chipselect.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:   bus.readdata = 32'(data_q);
            ADDR_MASK:   bus.readdata = 32'(mask_q);
            ADDR_HALF:   bus.readdata = 32'(half_q);
            ADDR_STATUS: bus.readdata = {30'd0, DECODE_PRESENT, phase_q};
            default:     bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_pio_hex_display_ctrl.sv
// Directed testbench for pio_hex_display_ctrl (NUM_DIGITS=4, ACTIVE_LOW=1).
// Expectations follow PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN when defined.
module tb_pio_hex_display_ctrl;

    logic        clk;
    logic        reset;
    logic [27:0] out_port;
    int unsigned n_vec;
    int unsigned n_bad;

    pio_hex_display_ctrl_if bus ();

    pio_hex_display_ctrl #(
        .NUM_DIGITS     (4),
        .ACTIVE_LOW     (1'b1),
        .BLINK_CNT_W    (26),
        .BLINK_HALF_RST (25000000),
        .RESET_DATA     (28'h0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    logic [31:0] v;
    logic        ph_prev, ph_now;

    initial begin
        n_vec = 0;
        n_bad = 0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset = 1'b1;
        #1;
        check("rst_out", 32'(out_port), 32'h0);
        rd(3'd2, v); check("rst_half", v, 32'd25000000);
        rd(3'd1, v); check("rst_mask", v, 32'h0);
        rd(3'd3, v);
`ifdef PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN
        check("rst_status", v, 32'h3);
`else
        check("rst_status", v, 32'h1);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic DATA write and output latency.
        wr(3'd0, 32'h0ABCDEF);
        rd(3'd0, v); check("data_rd", v, 32'h0ABCDEF);
        check("out_lat0", 32'(out_port), 32'h0);
        @(negedge clk);
        check("out_lat1", 32'(out_port), 32'h0ABCDEF);

        // Set / clear / width masking / RO and WO behaviour.
        wr(3'd0, 32'h0000F00);
        wr(3'd4, 32'h00000FF);
        rd(3'd0, v); check("outset", v, 32'h0000FFF);
        wr(3'd5, 32'h0000F0F);
        rd(3'd0, v); check("outclear", v, 32'h00000F0);
        rd(3'd4, v); check("wo_rd4", v, 32'h0);
        rd(3'd7, v); check("rsv_rd7", v, 32'h0);
        wr(3'd3, 32'hFFFFFFFF);
        rd(3'd3, v);
`ifdef PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN
        check("ro_ignore", v, 32'h3);
`else
        check("ro_ignore", v, 32'h1);
`endif
        wr(3'd0, 32'hFFFFFFFF);
        rd(3'd0, v); check("data_trunc", v, 32'h0FFFFFFF);
        wr(3'd1, 32'hFFFFFFF5);
        rd(3'd1, v); check("mask_trunc", v, 32'h5);
        wr(3'd1, 32'h0);

        // Hex decode port.
        wr(3'd0, 32'h0000123);
        wr(3'd6, 32'h0000A380);
        rd(3'd0, v);
`ifdef PIO_HEX_DISPLAY_CTRL_HEX_DECODE_EN
        check("hex_data", v, 32'h10C0040);
        @(negedge clk);
        check("hex_out", 32'(out_port), 32'h10C0040);
`else
        check("hex_ignored", v, 32'h0000123);
        @(negedge clk);
        check("hex_out", 32'(out_port), 32'h0000123);
`endif

        // Blink: half-period 4 on digit 1, DATA=0 (lit = 0x00, off = 0x7F).
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h2);
        wr(3'd2, 32'd4);
        ph_prev = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ph_now = ((k / 4) % 2) == 0;
            rd(3'd3, v);
            check($sformatf("blink_ph%0d", k), {31'd0, v[0]}, {31'd0, ph_now});
            check($sformatf("blink_out%0d", k), 32'(out_port), ph_prev ? 32'h0 : 32'h3F80);
            ph_prev = ph_now;
            @(negedge clk);
        end

        // Shrinking BLINK_HALF on the wrap cycle restarts lit without toggling.
        wr(3'd2, 32'd4);
        repeat (3) @(negedge clk);
        wr(3'd2, 32'd2);
        rd(3'd3, v); check("bnd_ph0", {31'd0, v[0]}, 32'd1);
        @(negedge clk);
        rd(3'd3, v); check("bnd_ph1", {31'd0, v[0]}, 32'd1);
        @(negedge clk);
        rd(3'd3, v); check("bnd_ph2", {31'd0, v[0]}, 32'd0);
        @(negedge clk);
        check("bnd_out", 32'(out_port), 32'h3F80);

        // BLINK_HALF=0 freezes phase high and the digit stays lit.
        wr(3'd2, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd(3'd3, v); check($sformatf("zero_ph%0d", k), {31'd0, v[0]}, 32'd1);
            check($sformatf("zero_out%0d", k), 32'(out_port), 32'h0);
        end

        // Asynchronous reset in the dark half of the period.
        wr(3'd0, 32'h0000055);
        wr(3'd2, 32'd2);
        repeat (2) @(negedge clk);
        rd(3'd3, v); check("pre_rst_ph", {31'd0, v[0]}, 32'd0);
        @(negedge clk);
        check("pre_rst_out", 32'(out_port), 32'h0003F80 | 32'h55);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out", 32'(out_port), 32'h0);
        rd(3'd0, v); check("arst_data", v, 32'h0);
        rd(3'd2, v); check("arst_half", v, 32'd25000000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(3'd3, v); check("arst_ph", {31'd0, v[0]}, 32'd1);
        rd(3'd1, v); check("arst_mask", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
